// File: rtl/jtag_pkg.sv
// jtag_pkg: definitions shared by the JTAG scan driver, its shifter and any TAP model.
//   op_e        : command opcodes carried on cmd_op
//   state_e     : driver sequencer states
//   tap_state_e : IEEE 1149.1 TAP controller states, same encoding as the TAP
//   DR_PRE, IR_PRE, POST, RESET_LEN : TMS preamble/postamble lengths in tck cycles
//   pre_len / pre_tms / is_scan     : per-opcode preamble length, preamble TMS bit, scan test
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_RUN_IDLE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PRE   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_POST  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam int DR_PRE    = 3;  // RTI -> Select-DR -> Capture-DR -> Shift-DR
  localparam int IR_PRE    = 4;  // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam int POST      = 2;  // Exit1 -> Update -> RTI
  localparam int RESET_LEN = 6;  // five ones reach Test-Logic-Reset from anywhere, one zero to RTI

  function automatic logic [2:0] pre_len(input op_e op);
    case (op)
      OP_RESET:    return 3'(RESET_LEN);
      OP_SHIFT_IR: return 3'(IR_PRE);
      OP_SHIFT_DR: return 3'(DR_PRE);
      default:     return 3'd0;
    endcase
  endfunction

  // TMS presented on preamble step 'step' of opcode 'op'.
  function automatic logic pre_tms(input op_e op, input logic [2:0] step);
    case (op)
      OP_RESET:    return step < 3'(RESET_LEN - 1);
      OP_SHIFT_IR: return step < 3'd2;
      OP_SHIFT_DR: return step == 3'd0;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_scan(input op_e op);
    return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
  endfunction

endpackage

// File: rtl/jtag_scan_shifter.sv
// jtag_scan_shifter: TDI shift-out register and TDO capture register.
//   tck, trst_n : clock, asynchronous active-low reset
//   load        : load load_data for shift-out and clear the capture register
//   shift       : present the next LSB on tdi (registered) and shift right
//   capture     : store tdo into cap_data[cap_idx]
//   tdi         : registered TDI bit; 0 whenever not shifting
//   cap_data    : captured TDO bits; bits never captured since load read 0
module jtag_scan_shifter
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               load,
  input  logic               shift,
  input  logic               capture,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]   cap_idx,
  input  logic               tdo,
  output logic               tdi,
  output logic [MAX_LEN-1:0] cap_data
);

  logic [MAX_LEN-1:0] tdi_sr_reg;
  logic               tdi_reg;
  logic [MAX_LEN-1:0] cap_reg;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdi_sr_reg <= '0;
      tdi_reg    <= 1'b0;
    end else if (load) begin
      tdi_sr_reg <= load_data;
      tdi_reg    <= 1'b0;
    end else if (shift) begin
      tdi_reg    <= tdi_sr_reg[0];
      tdi_sr_reg <= tdi_sr_reg >> 1;
    end else begin
      tdi_reg    <= 1'b0;
    end
  end

  // Indexed capture keeps rsp_data[i] aligned to bit i regardless of scan length.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_cap
      always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
          cap_reg[gi] <= 1'b0;
        end else if (load) begin
          cap_reg[gi] <= 1'b0;
        end else if (capture && (cap_idx == LEN_W'(gi))) begin
          cap_reg[gi] <= tdo;
        end
      end
    end
  endgenerate

  assign tdi      = tdi_reg;
  assign cap_data = cap_reg;

endmodule

// File: rtl/jtag_scan_driver.sv
// jtag_scan_driver: host-side JTAG sequencer in front of a TAP.
//   tck, trst_n          : clock, asynchronous active-low reset
//   cmd_*                : command channel (op, length, TDI data), valid/ready
//   rsp_*                : response channel (captured TDO, error flag), valid/ready
//   tap_tms/tdi/en       : registered TAP drive; tap_tdo : TAP output
// Outputs for cycle N+1 are computed from the next state and registered at edge N,
// so each TMS/TDI value appears exactly in the cycle its state occupies.
module jtag_scan_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tap_tms,
  output logic               tap_tdi,
  output logic               tap_en,
  input  logic               tap_tdo
);

  state_e           state_reg, state_next;
  op_e              op_reg, op_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [2:0]       step_reg, step_next;
  logic [LEN_W-1:0] bit_reg, bit_next;
  logic             tms_reg, tms_next;
  logic             en_reg, en_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             load, shift, capture;
  logic             last_bit, scan, len_bad;

  assign last_bit = (bit_reg == len_reg - LEN_W'(1));
  assign scan     = is_scan(op_reg);
  assign len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_reg <= ST_SYNC;
      op_reg    <= OP_RESET;
      len_reg   <= '0;
      step_reg  <= '0;
      bit_reg   <= '0;
      tms_reg   <= 1'b1;
      en_reg    <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      len_reg   <= len_next;
      step_reg  <= step_next;
      bit_reg   <= bit_next;
      tms_reg   <= tms_next;
      en_reg    <= en_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    len_next   = len_reg;
    step_next  = step_reg;
    bit_next   = bit_reg;
    tms_next   = 1'b0;
    en_next    = 1'b1;
    valid_next = valid_reg;
    err_next   = err_reg;
    load       = 1'b0;
    shift      = 1'b0;
    capture    = 1'b0;

    case (state_reg)
      ST_SYNC: begin
        // First cycle out of reset only enables the TAP; steps 0..5 then carry 1,1,1,1,1,0.
        if (!en_reg) begin
          tms_next  = 1'b1;
          step_next = '0;
        end else if (step_reg == 3'(RESET_LEN - 1)) begin
          state_next = ST_IDLE;
        end else begin
          step_next = step_reg + 3'd1;
          tms_next  = step_reg < 3'(RESET_LEN - 2);
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          op_next  = op_e'(cmd_op);
          len_next = cmd_len;
          load     = 1'b1;
          err_next = 1'b0;
          if (len_bad) begin
            state_next = ST_RESP;
            valid_next = 1'b1;
            err_next   = 1'b1;
          end else if (op_e'(cmd_op) == OP_RUN_IDLE) begin
            state_next = ST_SHIFT;
            bit_next   = '0;
          end else begin
            state_next = ST_PRE;
            step_next  = '0;
            tms_next   = pre_tms(op_e'(cmd_op), 3'd0);
          end
        end
      end

      ST_PRE: begin
        if (step_reg == pre_len(op_reg) - 3'd1) begin
          if (op_reg == OP_RESET) begin
            state_next = ST_RESP;
            valid_next = 1'b1;
          end else begin
            state_next = ST_SHIFT;
            bit_next   = '0;
            shift      = 1'b1;
            tms_next   = (len_reg == LEN_W'(1));
          end
        end else begin
          step_next = step_reg + 3'd1;
          tms_next  = pre_tms(op_reg, step_reg + 3'd1);
        end
      end

      ST_SHIFT: begin
        // The edge ending this cycle clocks bit_reg into the TAP, so tdo is captured now.
        capture = scan;
        if (last_bit) begin
          if (scan) begin
            state_next = ST_POST;
            step_next  = '0;
            tms_next   = 1'b1;
          end else begin
            state_next = ST_RESP;
            valid_next = 1'b1;
          end
        end else begin
          bit_next = bit_reg + LEN_W'(1);
          shift    = scan;
          tms_next = scan && (bit_reg + LEN_W'(2) == len_reg);
        end
      end

      ST_POST: begin
        if (step_reg == 3'(POST - 1)) begin
          state_next = ST_RESP;
          valid_next = 1'b1;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_SYNC;
        en_next    = 1'b0;
        tms_next   = 1'b1;
      end
    endcase
  end

  jtag_scan_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .tck      (tck),
    .trst_n   (trst_n),
    .load     (load),
    .shift    (shift),
    .capture  (capture),
    .load_data(cmd_data),
    .cap_idx  (bit_reg),
    .tdo      (tap_tdo),
    .tdi      (tap_tdi),
    .cap_data (rsp_data)
  );

  // RESP is only left via the handshake, so IDLE always has rsp_valid low.
  assign cmd_ready = (state_reg == ST_IDLE);
  assign rsp_valid = valid_reg;
  assign rsp_err   = err_reg;
  assign tap_tms   = tms_reg;
  assign tap_en    = en_reg;

endmodule

// File: tb/tb_jtag_scan_driver.sv
// tb_jtag_scan_driver: directed bench for jtag_scan_driver with a behavioural TAP
// (4-bit IR, IDCODE 32'h000FAF01 selected by IR 4'hE, bypass otherwise).
module tb_jtag_scan_driver;
  import jtag_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam logic [3:0]  IR_IDCODE = 4'hE;
  localparam logic [31:0] IDCODE    = 32'h000FAF01;

  logic               tck = 1'b0;
  logic               trst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               tap_tms, tap_tdi, tap_en;
  logic               tap_tdo;

  int vectors = 0;
  int miscompares = 0;

  always #5 tck = ~tck;

  jtag_scan_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck(tck), .trst_n(trst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tap_tms(tap_tms), .tap_tdi(tap_tdi), .tap_en(tap_en), .tap_tdo(tap_tdo)
  );

  // ---------------- behavioural TAP ----------------
  tap_state_e  ts;
  logic [3:0]  ir_reg, ir_sr;
  logic [31:0] dr_sr;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:      return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   return tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   return tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   return tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   return tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      default:      return tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ts     <= TAP_TLR;
      ir_reg <= IR_IDCODE;
      ir_sr  <= 4'h0;
      dr_sr  <= 32'h0;
    end else if (tap_en) begin
      case (ts)
        TAP_TLR:      ir_reg <= IR_IDCODE;
        TAP_CAP_DR:   dr_sr  <= (ir_reg == IR_IDCODE) ? IDCODE : 32'h0;
        TAP_SHIFT_DR: dr_sr  <= (ir_reg == IR_IDCODE) ? {tap_tdi, dr_sr[31:1]} : {31'h0, tap_tdi};
        TAP_CAP_IR:   ir_sr  <= 4'b0001;
        TAP_SHIFT_IR: ir_sr  <= {tap_tdi, ir_sr[3:1]};
        TAP_UPD_IR:   ir_reg <= ir_sr;
        default: ;
      endcase
      ts <= tap_next(ts, tap_tms);
    end
  end

  always @(negedge tck or negedge trst_n) begin
    if (!trst_n)                 tap_tdo <= 1'b0;
    else if (ts == TAP_SHIFT_DR) tap_tdo <= dr_sr[0];
    else if (ts == TAP_SHIFT_IR) tap_tdo <= ir_sr[0];
    else                         tap_tdo <= 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Returns in the first cycle after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len,
                      input logic [MAX_LEN-1:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    chk("accept_in_time", 64'(n < 100), 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
  endtask

  // Called right after trst_n rises (one ns past an edge).
  task automatic sync_check(input string tag);
    logic [5:0] sync_tms;
    sync_tms = 6'b011111;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      if (k <= 6) begin
        chk({tag, "_tms"}, 64'(tap_tms), 64'(sync_tms[k-1]));
        chk({tag, "_en"}, 64'(tap_en), 64'd1);
        chk({tag, "_ready_low"}, 64'(cmd_ready), 64'd0);
      end else begin
        chk({tag, "_ready_c7"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_tap_rti"}, 64'(ts), 64'(TAP_RTI));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tms"}, 64'(tap_tms), 64'd1);
    chk({tag, "_tdi"}, 64'(tap_tdi), 64'd0);
    chk({tag, "_en"}, 64'(tap_en), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0]       ir_tms;
    logic [3:0]       ir_data;
    logic [5:0]       rst_tms;
    logic [15:0]      mid_data;
    logic [LEN_W-1:0] bad_len;

    ir_tms   = 10'b0110000011;   // cycle c -> bit c-1: 1,1,0,0,0,0,0,1,1,0
    ir_data  = 4'hE;
    rst_tms  = 6'b011111;
    mid_data = 16'h1234;

    // Reset values
    repeat (3) @(posedge tck);
    #1;
    chk_reset_outputs("reset");
    trst_n = 1'b1;
    sync_check("sync");

    // SHIFT_IR len 4, data E
    send(2'd1, 6'd4, 32'hE);
    for (int c = 1; c <= 10; c++) begin
      chk("ir_tms", 64'(tap_tms), 64'(ir_tms[c-1]));
      chk("ir_rsp_early", 64'(rsp_valid), 64'd0);
      if (c >= 5 && c <= 8) chk("ir_tdi", 64'(tap_tdi), 64'(ir_data[c-5]));
      step();
    end
    chk("ir_rsp_valid_c11", 64'(rsp_valid), 64'd1);
    chk("ir_rsp_err", 64'(rsp_err), 64'd0);
    chk("ir_rsp_data", 64'(rsp_data), 64'h1);
    chk("ir_tap_ir", 64'(ir_reg), 64'hE);
    chk("ir_tap_rti", 64'(ts), 64'(TAP_RTI));
    take_rsp();

    // SHIFT_DR len 32 reads IDCODE
    send(2'd2, 6'd32, 32'h0);
    wait_rsp(38, "dr32");
    chk("dr32_data", 64'(rsp_data), 64'h000FAF01);
    chk("dr32_err", 64'(rsp_err), 64'd0);
    chk("dr32_tap_rti", 64'(ts), 64'(TAP_RTI));
    take_rsp();

    // RESET command
    send(2'd0, 6'd1, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      chk("rst_tms", 64'(tap_tms), 64'(rst_tms[c-1]));
      chk("rst_rsp_early", 64'(rsp_valid), 64'd0);
      step();
    end
    chk("rst_rsp_valid_c7", 64'(rsp_valid), 64'd1);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_tap_rti", 64'(ts), 64'(TAP_RTI));
    take_rsp();

    // RUN_IDLE len 5
    send(2'd3, 6'd5, 32'hFFFF_FFFF);
    for (int c = 1; c <= 5; c++) begin
      chk("run_tms", 64'(tap_tms), 64'd0);
      chk("run_tdi", 64'(tap_tdi), 64'd0);
      chk("run_rsp_early", 64'(rsp_valid), 64'd0);
      step();
    end
    chk("run_rsp_valid_c6", 64'(rsp_valid), 64'd1);
    chk("run_rsp_data", 64'(rsp_data), 64'd0);
    chk("run_tap_rti", 64'(ts), 64'(TAP_RTI));
    take_rsp();

    // Illegal lengths 0 and 33
    for (int j = 0; j < 2; j++) begin
      bad_len = (j == 0) ? 6'd0 : 6'd33;
      send(2'd2, bad_len, 32'hFFFF_FFFF);
      chk("bad_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bad_rsp_err", 64'(rsp_err), 64'd1);
      chk("bad_rsp_data", 64'(rsp_data), 64'd0);
      chk("bad_tms", 64'(tap_tms), 64'd0);
      take_rsp();
    end

    // Backpressure: response held 10 cycles while the next command waits
    send(2'd2, 6'd8, 32'hA5);
    wait_rsp(14, "bp_dr8");
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 6'd3;
    cmd_data  = '0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(rsp_data), 64'h01);
      chk("bp_rsp_err", 64'(rsp_err), 64'd0);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    take_rsp();
    send(2'd3, 6'd3, 32'h0);
    wait_rsp(4, "bp_run3");
    take_rsp();

    // Reset mid DR shift at bit 5 of 16
    send(2'd2, 6'd16, 32'(mid_data));
    repeat (8) step();
    chk("mid_tdi_bit5", 64'(tap_tdi), 64'(mid_data[5]));
    #1;
    trst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) step();
    trst_n = 1'b1;
    sync_check("resync");
    send(2'd2, 6'd16, 32'h0);
    wait_rsp(22, "dr16");
    chk("dr16_data", 64'(rsp_data), 64'h0000AF01);
    chk("dr16_err", 64'(rsp_err), 64'd0);
    take_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
